riscv_mmio_uart: RTL and testbench

//  Memory-mapped console/termination peripheral on the data-memory bus of the single-cycle RV32I core.
//  The core writes bytes into TXDATA. The block buffers them in a FIFO and serializes them 8N1 on o_uart_tx.
//  The core writes TOHOST to end a program run: o_halt and o_exit_code give the bench a pass/fail signal.
//  It sits beside riscv_dmem. The top uses o_sel to choose this block's o_rd_data over dmem read data.

---
 rtl/riscv_mmio_uart.sv | 188 ++++++++++++++++++
 tb/tb_riscv_mmio_uart.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mmio_uart.sv
// Memory-mapped console UART and TOHOST termination register for the RV32I core.
// Stores to TXDATA are queued in a small FIFO and sent 8N1; a TOHOST store latches the halt/exit code.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | driving the start bit (0)
// S_DATA  | shifting out 8 data bits, LSB first
// S_STOP  | driving the stop bit (1), then chain or idle
module riscv_mmio_uart #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_addr,
    input  logic        i_wr_en,
    input  logic [3:0]  i_byte_sel,
    input  logic [31:0] i_wr_data,
    output logic        o_sel,
    output logic [31:0] o_rd_data,
    output logic        o_uart_tx,
    output logic        o_halt,
    output logic [31:0] o_exit_code
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state;
    logic [15:0]   bit_tmr;
    logic [15:0]   frame_div;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [15:0]   divisor;

    logic [1:0]    reg_off;
    logic          wr_hit;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          ovf_clr;
    logic          div_wr;
    logic [15:0]   div_next;
    logic          unused_ok;

    assign unused_ok  = ^{i_addr[1:0], i_byte_sel[3:2]};

    assign o_sel      = (i_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_off    = i_addr[3:2];
    assign wr_hit     = i_wr_en & o_sel;
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);

    // Pop is driven by the FSM: on leaving IDLE or at the end of a stop bit.
    assign pop      = !fifo_empty &&
                      ((state == S_IDLE) || ((state == S_STOP) && (bit_tmr == 16'd0)));
    assign push_req = wr_hit && (reg_off == 2'd0) && i_byte_sel[0];
    assign push     = push_req && (!fifo_full || pop);
    assign ovf_clr  = wr_hit && (reg_off == 2'd1) && i_byte_sel[0] && i_wr_data[3];
    assign div_wr   = wr_hit && (reg_off == 2'd2) && (i_byte_sel[0] || i_byte_sel[1]);

    always_comb begin
        div_next = divisor;
        if (i_byte_sel[0]) div_next[7:0]  = i_wr_data[7:0];
        if (i_byte_sel[1]) div_next[15:8] = i_wr_data[15:8];
        if (div_next == 16'd0) div_next = 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_wr_data[7:0];
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && fifo_full && !pop) overflow <= 1'b1;
            else if (ovf_clr)                  overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            divisor     <= DIV_RESET;
            o_halt      <= 1'b0;
            o_exit_code <= '0;
        end else begin
            if (div_wr) divisor <= div_next;
            if (wr_hit && (reg_off == 2'd3) && !o_halt) begin
                o_halt      <= 1'b1;
                o_exit_code <= i_wr_data;
            end
        end
    end

    // frame_div holds the bit time for the whole frame so DIVISOR writes apply from the next start.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= S_IDLE;
            bit_tmr   <= '0;
            frame_div <= DIV_RESET;
            shreg     <= '0;
            bit_idx   <= '0;
            o_uart_tx <= 1'b1;
        end else if (state == S_IDLE) begin
            if (pop) begin
                state     <= S_START;
                shreg     <= mem[rd_ptr];
                frame_div <= divisor;
                bit_tmr   <= divisor - 16'd1;
                o_uart_tx <= 1'b0;
            end
        end else if (bit_tmr != 16'd0) begin
            bit_tmr <= bit_tmr - 16'd1;
        end else begin
            bit_tmr <= frame_div - 16'd1;
            case (state)
                S_START: begin
                    state     <= S_DATA;
                    bit_idx   <= '0;
                    o_uart_tx <= shreg[0];
                    shreg     <= shreg >> 1;
                end
                S_DATA: begin
                    if (bit_idx == 3'd7) begin
                        state     <= S_STOP;
                        o_uart_tx <= 1'b1;
                    end else begin
                        bit_idx   <= bit_idx + 3'd1;
                        o_uart_tx <= shreg[0];
                        shreg     <= shreg >> 1;
                    end
                end
                default: begin
                    if (pop) begin
                        state     <= S_START;
                        shreg     <= mem[rd_ptr];
                        frame_div <= divisor;
                        bit_tmr   <= divisor - 16'd1;
                        o_uart_tx <= 1'b0;
                    end else begin
                        state     <= S_IDLE;
                        o_uart_tx <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        logic [7:0] count8;
        count8            = '0;
        count8[CW-1:0]    = fifo_count;
        o_rd_data         = '0;
        if (o_sel) begin
            case (reg_off)
                2'd1:    o_rd_data = {16'd0, count8, 4'd0, overflow, fifo_empty, fifo_full,
                                      (state != S_IDLE)};
                2'd2:    o_rd_data = {16'd0, divisor};
                2'd3:    o_rd_data = o_exit_code;
                default: o_rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mmio_uart.sv
// Self-checking bench for riscv_mmio_uart: a line monitor decodes frames and checks them
// against bytes queued when TXDATA stores are issued; register behaviour is checked directly.
module tb_riscv_mmio_uart;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_DV = BASE + 32'h8;
    localparam logic [31:0] A_TH = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = 32'd0;
    logic        wr_en = 1'b0;
    logic [3:0]  be = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        sel;
    logic [31:0] rd_data;
    logic        tx;
    logic        halt;
    logic [31:0] exit_code;

    int          n_vec = 0;
    int          n_err = 0;
    int          extra_frames = 0;
    int          mon_div = 868;
    logic        mon_en = 1'b0;
    logic [7:0]  exp_q [$];

    riscv_mmio_uart dut (
        .i_clk       (clk),
        .i_rstn      (rst_n),
        .i_addr      (addr),
        .i_wr_en     (wr_en),
        .i_byte_sel  (be),
        .i_wr_data   (wdata),
        .o_sel       (sel),
        .o_rd_data   (rd_data),
        .o_uart_tx   (tx),
        .o_halt      (halt),
        .o_exit_code (exit_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        addr = a; wdata = d; be = b; wr_en = 1'b1;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; wr_en = 1'b0;
        #1 d = rd_data;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4 * mon_div) @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Line monitor: finds a start bit, samples mid-bit, compares against the scoreboard.
    initial begin
        logic [7:0] b;
        logic       stop;
        int         d;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx === 1'b0) begin
                d = mon_div;
                repeat (d / 2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (d) @(negedge clk);
                    b[j] = tx;
                end
                repeat (d) @(negedge clk);
                stop = tx;
                if (mon_en) begin
                    chk("stop_bit", 64'(stop), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("rx_byte", 64'(b), 64'(e));
                    end else begin
                        extra_frames++;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [63:0] obs_tx, obs_busy, exp_tx, exp_busy;
        logic [7:0]  v;
        logic [7:0]  pat;

        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_halt", 64'(halt), 64'd0);
        chk("rst_exit", 64'(exit_code), 64'd0);
        rd(A_ST, r); chk("rst_status", 64'(r), 64'h4);
        chk("sel_in", 64'(sel), 64'd1);
        rd(A_DV, r); chk("rst_div", 64'(r), 64'd868);
        rd(A_TX, r); chk("txdata_rd", 64'(r), 64'd0);

        wr(A_DV, 32'h0, 4'hF);       rd(A_DV, r); chk("div_zero", 64'(r), 64'd1);
        wr(A_DV, 32'h34, 4'b0001);   rd(A_DV, r); chk("div_lane0", 64'(r), 64'h34);
        wr(A_DV, 32'h1200, 4'b0010); rd(A_DV, r); chk("div_lane1", 64'(r), 64'h1234);

        // Exact 0x55 waveform at DIVISOR=4
        wr(A_DV, 32'd4, 4'hF);
        mon_div = 4; mon_en = 1'b1;
        pat = 8'h55;
        exp_q.push_back(pat);
        wr(A_TX, 32'(pat), 4'h1);
        addr = A_ST;
        obs_tx = '0; obs_busy = '0; exp_tx = '0; exp_busy = '0;
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            obs_tx[i]   = tx;
            obs_busy[i] = rd_data[0];
            if (i == 0 || i == 41) begin
                exp_tx[i] = 1'b1;
            end else begin
                exp_busy[i] = 1'b1;
                if ((i - 1) / 4 == 0)      exp_tx[i] = 1'b0;
                else if ((i - 1) / 4 == 9) exp_tx[i] = 1'b1;
                else                       exp_tx[i] = pat[(i - 1) / 4 - 1];
            end
        end
        chk("wave_tx", obs_tx, exp_tx);
        chk("wave_busy", obs_busy, exp_busy);
        drain(200);

        // Ten back-to-back stores: the tenth lands on a full FIFO
        for (int i = 0; i < 10; i++) begin
            v = 8'($urandom_range(0, 255));
            if (i < 9) exp_q.push_back(v);
            wr(A_TX, 32'(v), 4'h1);
        end
        rd(A_ST, r); chk("ovf_status", 64'(r), 64'h80B);
        wr(A_ST, 32'h8, 4'hF);
        rd(A_ST, r); chk("ovf_clear", 64'(r), 64'h803);
        drain(1000);
        chk("extra_frames_ovf", 64'(extra_frames), 64'd0);
        rd(A_ST, r); chk("idle_status", 64'(r), 64'h4);

        // Divisor write mid-frame only affects the next frame
        exp_q.push_back(8'hA5);
        wr(A_TX, 32'hA5, 4'h1);
        repeat (10) @(negedge clk);
        wr(A_DV, 32'd8, 4'h3);
        rd(A_DV, r); chk("div_mid", 64'(r), 64'd8);
        drain(200);
        mon_div = 8;
        exp_q.push_back(8'h3C);
        wr(A_TX, 32'h3C, 4'h1);
        drain(300);

        // Stores outside the window
        wr(BASE + 32'h10, 32'hFF, 4'hF);
        chk("oow_sel", 64'(sel), 64'd0);
        chk("oow_rd", 64'(rd_data), 64'd0);
        wr(BASE + 32'h14, 32'h8, 4'hF);
        wr(BASE + 32'h18, 32'h0, 4'hF);
        wr(BASE + 32'h1C, 32'hDEAD, 4'hF);
        repeat (4) @(negedge clk);
        chk("oow_tx", 64'(tx), 64'd1);
        chk("oow_halt", 64'(halt), 64'd0);
        rd(A_ST, r); chk("oow_status", 64'(r), 64'h4);
        rd(A_DV, r); chk("oow_div", 64'(r), 64'd8);

        // TOHOST
        wr(A_TH, 32'h1, 4'hF);
        chk("th_halt", 64'(halt), 64'd1);
        chk("th_exit", 64'(exit_code), 64'd1);
        wr(A_TH, 32'h7, 4'hF);
        chk("th_sticky", 64'(exit_code), 64'd1);
        rd(A_TH, r); chk("th_rd", 64'(r), 64'd1);

        // Asynchronous reset in the middle of a frame
        mon_en = 1'b0;
        wr(A_TX, 32'h00, 4'h1);
        repeat (20) @(negedge clk);
        chk("pre_rst_tx", 64'(tx), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 64'(tx), 64'd1);
        chk("async_rst_halt", 64'(halt), 64'd0);
        chk("async_rst_exit", 64'(exit_code), 64'd0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        rd(A_ST, r); chk("post_rst_status", 64'(r), 64'h4);
        rd(A_DV, r); chk("post_rst_div", 64'(r), 64'd868);
        chk("extra_frames", 64'(extra_frames), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
